// File: rtl/ula_op_sequencer.sv
// ula_op_sequencer: pops one or two operands off the data stack into the ALU,
// writes the ALU result back, and updates the entry count (TOS).
`default_nettype none

module ula_op_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  OP_VALID,
  output logic                  OP_READY,
  input  logic [3:0]            OP_SEL,
  input  logic [ADDR_WIDTH-1:0] TOS_IN,
  output logic [ADDR_WIDTH-1:0] STACK_ADDR,
  input  logic [DATA_WIDTH-1:0] STACK_RDATA,
  output logic [DATA_WIDTH-1:0] OPND_OUT,
  output logic                  CTRL_REG_OP1,
  output logic                  CTRL_REG_OP2,
  output logic [3:0]            SEL_ULA,
  input  logic [DATA_WIDTH-1:0] ULA_RESULT_IN,
  output logic                  STACK_WE,
  output logic [DATA_WIDTH-1:0] STACK_WDATA,
  output logic                  CTRL_REG_OVERFLOW,
  output logic                  CTRL_STACK_COMP,
  output logic [ADDR_WIDTH-1:0] TOS_OUT,
  output logic                  TOS_WE,
  output logic                  DONE,
  output logic                  ERR
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    POP1 = 3'd1,
    POP2 = 3'd2,
    EXEC = 3'd3,
    FIN  = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_TWO = ADDR_WIDTH'(2);

  state_t                  state, state_nxt;
  logic [3:0]              op_q;
  logic [ADDR_WIDTH-1:0]   tos_q;
  logic                    err_q;

  logic                    accept;
  logic                    in_unary, in_illegal, in_underflow, in_err;
  logic                    op_unary, op_ovf, op_cmp;

  function automatic logic is_unary(input logic [3:0] code);
    return code == 4'b1000;
  endfunction

  function automatic logic is_illegal(input logic [3:0] code);
    return code == 4'b1111;
  endfunction

  // Overflow register tracks only the arithmetic subset of the binary ops.
  function automatic logic is_ovf_op(input logic [3:0] code);
    return code <= 4'b0100;
  endfunction

  function automatic logic is_cmp_op(input logic [3:0] code);
    return (code >= 4'b1001) && (code <= 4'b1110);
  endfunction

  assign accept       = OP_VALID && (state == IDLE);
  assign in_unary     = is_unary(OP_SEL);
  assign in_illegal   = is_illegal(OP_SEL);
  assign in_underflow = in_unary ? (TOS_IN == '0) : (TOS_IN < ADDR_TWO);
  assign in_err       = in_illegal || in_underflow;

  assign op_unary = is_unary(op_q);
  assign op_ovf   = is_ovf_op(op_q);
  assign op_cmp   = is_cmp_op(op_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_q  <= 4'b0000;
      tos_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q  <= OP_SEL;
        tos_q <= TOS_IN;
        err_q <= in_err;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = in_err ? FIN : POP1;
      POP1: state_nxt = op_unary ? EXEC : POP2;
      POP2: state_nxt = EXEC;
      EXEC: state_nxt = FIN;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from state so that reset silences every strobe at once.
  always_comb begin
    OP_READY          = 1'b0;
    STACK_ADDR        = '0;
    OPND_OUT          = '0;
    CTRL_REG_OP1      = 1'b0;
    CTRL_REG_OP2      = 1'b0;
    STACK_WE          = 1'b0;
    STACK_WDATA       = '0;
    CTRL_REG_OVERFLOW = 1'b0;
    CTRL_STACK_COMP   = 1'b0;
    TOS_OUT           = '0;
    TOS_WE            = 1'b0;
    DONE              = 1'b0;
    ERR               = 1'b0;
    case (state)
      IDLE: OP_READY = 1'b1;
      POP1: begin
        STACK_ADDR   = tos_q - ADDR_ONE;
        OPND_OUT     = STACK_RDATA;
        CTRL_REG_OP1 = 1'b1;
      end
      POP2: begin
        STACK_ADDR   = tos_q - ADDR_TWO;
        OPND_OUT     = STACK_RDATA;
        CTRL_REG_OP2 = 1'b1;
      end
      EXEC: begin
        STACK_ADDR        = op_unary ? (tos_q - ADDR_ONE) : (tos_q - ADDR_TWO);
        STACK_WE          = 1'b1;
        STACK_WDATA       = ULA_RESULT_IN;
        CTRL_REG_OVERFLOW = op_ovf;
        CTRL_STACK_COMP   = op_cmp;
      end
      FIN: begin
        DONE = 1'b1;
        ERR  = err_q;
        if (!err_q) begin
          TOS_WE  = 1'b1;
          TOS_OUT = op_unary ? tos_q : (tos_q - ADDR_ONE);
        end
      end
      default: ;
    endcase
  end

  assign SEL_ULA = op_q;

endmodule

`default_nettype wire

// File: doc/ula_op_sequencer.md
ULA_OP_SEQUENCER -- requirements
Module: ula_op_sequencer

Interface
- REQ-001 SHALL have parameter DATA_WIDTH, default 8: stack word and ALU operand width.
- REQ-002 SHALL have parameter ADDR_WIDTH, default 12: stack address and TOS width.
- REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
- REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
- REQ-005 SHALL have port OP_VALID, input, 1: operation request.
- REQ-006 SHALL have port OP_READY, output, 1: sequencer can accept a request.
- REQ-007 SHALL have port OP_SEL, input, 4: ALU operation code.
- REQ-008 SHALL have port TOS_IN, input, ADDR_WIDTH: current entry count; the top entry is at TOS_IN-1.
- REQ-009 SHALL have port STACK_ADDR, output, ADDR_WIDTH: read/write address to the data stack; also drives the ALU TOS input.
- REQ-010 SHALL have port STACK_RDATA, input, DATA_WIDTH: asynchronous-read data at STACK_ADDR.
- REQ-011 SHALL have port OPND_OUT, output, DATA_WIDTH: operand to the ALU operand-register input.
- REQ-012 SHALL have port CTRL_REG_OP1 / CTRL_REG_OP2, output, 1 each: ALU operand-register load strobes.
- REQ-013 SHALL have port SEL_ULA, output, 4: latched operation code to the ALU.
- REQ-014 SHALL have port ULA_RESULT_IN, input, DATA_WIDTH: ALU result.
- REQ-015 SHALL have port STACK_WE, output, 1: data-stack write strobe.
- REQ-016 SHALL have port STACK_WDATA, output, DATA_WIDTH: data-stack write data.
- REQ-017 SHALL have port CTRL_REG_OVERFLOW / CTRL_STACK_COMP, output, 1 each: ALU overflow-register and compare-stack write strobes.
- REQ-018 SHALL have port TOS_OUT, output, ADDR_WIDTH, plus TOS_WE, output, 1: new entry count and its update strobe.
- REQ-019 SHALL have port DONE, output, 1, plus ERR, output, 1: completion pulse and error flag.

Function
- REQ-020 SHALL implement FSM states IDLE, POP1, POP2, EXEC, FIN; OP_READY=1 only in IDLE.
- REQ-021 SHALL accept a request when OP_VALID&&OP_READY, latching OP_SEL and TOS_IN (T), then move to POP1, or to FIN with ERR if illegal.
- REQ-022 SHALL classify codes: 0000-0111 binary arithmetic/logic; 1000 unary (NOT); 1001-1110 binary compare; 1111 illegal.
- REQ-023 SHALL flag underflow when T<2 (binary) or T<1 (unary); underflow and illegal go to FIN with ERR=1 and no strobes, no TOS_WE.
- REQ-024 POP1: STACK_ADDR=T-1, OPND_OUT=STACK_RDATA, CTRL_REG_OP1=1; next state POP2 (binary) or EXEC (unary).
- REQ-025 POP2: STACK_ADDR=T-2, OPND_OUT=STACK_RDATA, CTRL_REG_OP2=1; next state EXEC. Result = (T-2 entry) op (T-1 entry).
- REQ-026 EXEC: STACK_ADDR=T-2 (binary) or T-1 (unary); STACK_WE=1; STACK_WDATA=ULA_RESULT_IN; CTRL_REG_OVERFLOW=1 for codes 0000-0100; CTRL_STACK_COMP=1 for 1001-1110.
- REQ-027 FIN: DONE=1 for one cycle; TOS_WE=1 with TOS_OUT=T-1 (binary) or T (unary) unless error; return to IDLE.
- REQ-028 Latency: accept-to-DONE SHALL be 4 cycles binary, 3 unary, 1 error; back-to-back accept no earlier than the cycle after FIN.
- REQ-029 SEL_ULA SHALL hold the latched code from the cycle after accept until IDLE re-entry; strobes SHALL be asserted only in the states named above.
- REQ-030 Address arithmetic SHALL be modulo 2^ADDR_WIDTH; T=2^ADDR_WIDTH-1 SHALL be legal.
- REQ-031 OP_SEL/TOS_IN changes after accept SHALL NOT affect the operation in progress.

Reset
- REQ-032 rst_n low SHALL immediately force IDLE and outputs: OP_READY=1, all strobes 0, DONE=0, ERR=0, SEL_ULA=0, STACK_ADDR=0, TOS_OUT=0, OPND_OUT=0.
- REQ-033 Reset during POP1..FIN SHALL abandon the operation; no STACK_WE or TOS_WE after reset assertion.
- REQ-034 The first accept SHALL be possible in the first clk edge after rst_n rises.

Verification
- REQ-035 ADD: stack [5,7], T=2, OP_SEL=0000 -> OP1 loads 7, OP2 loads 5, write 12 at addr 0, TOS_OUT=1, DONE 4 cycles after accept.
- REQ-036 SUB: stack [3,9], T=2, OP_SEL=0001 -> ALU sees IN_2=3, IN_1=9; CTRL_REG_OVERFLOW=1 in EXEC; TOS_OUT=1.
- REQ-037 NOT: T=1, top=0x0F, OP_SEL=1000 -> no OP2 strobe, write 0xF0 at addr 0, TOS_OUT=1, DONE 3 cycles after accept.
- REQ-038 Compare: T=3, OP_SEL=1001 -> CTRL_STACK_COMP=1 with STACK_ADDR=1, TOS_OUT=2.
- REQ-039 Errors: T=1 with OP_SEL=0000, and OP_SEL=1111 -> DONE and ERR next cycle, no STACK_WE/TOS_WE.
- REQ-040 rst_n low during POP2 -> all strobes 0 at once, OP_READY=1, no write; next op completes normally.
